// File: rtl/turfbus_master.sv
// turfbus_master: WISHBONE classic slave to TURFbus initiator.
// Each access becomes one TD/TREQ_neg/SREQ_neg link transaction.
`timescale 1ns/1ps
module turfbus_master #(
    parameter int          TIMEOUT  = 1023,
    parameter logic [31:0] ERR_DATA = 32'hDEADDEAD
) (
    input  logic        wbs_clk_i,
    input  logic        wbs_rst_n_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [19:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o,
    output logic        TREQ_neg,
    input  logic        SREQ_neg,
    input  logic [7:0]  TD_i,
    output logic [7:0]  TD_o,
    output logic [7:0]  TD_oe,
    output logic        busy_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, HDR, ADR2, ADR1, ADR0,
        WD3, WD2, WD1, WD0,
        TURN, WAIT, RD2, RD1, RD0, DONE
    } state_t;

    state_t        state;
    logic          sreq_q;
    logic [7:0]    td_q;
    logic          we_q;
    logic [19:0]   adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic [23:0]   rdata;
    logic [CW-1:0] cnt;

    assign wbs_rty_o = 1'b0;

    always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
        if (!wbs_rst_n_i) begin
            state     <= IDLE;
            sreq_q    <= 1'b1;
            td_q      <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rdata     <= '0;
            cnt       <= '0;
            TREQ_neg  <= 1'b1;
            TD_o      <= '0;
            TD_oe     <= 8'hFF;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
            busy_o    <= 1'b0;
        end else begin
            sreq_q    <= SREQ_neg;
            td_q      <= TD_i;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o && !wbs_err_o) begin
                        we_q     <= wbs_we_i;
                        adr_q    <= wbs_adr_i;
                        dat_q    <= wbs_dat_i;
                        sel_q    <= wbs_sel_i;
                        TD_o     <= {wbs_we_i, 3'b000, wbs_sel_i};
                        TREQ_neg <= 1'b0;
                        busy_o   <= 1'b1;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    TD_o  <= {4'h0, adr_q[19:16]};
                    state <= ADR2;
                end
                ADR2: begin
                    TD_o  <= adr_q[15:8];
                    state <= ADR1;
                end
                ADR1: begin
                    TD_o  <= adr_q[7:0];
                    state <= ADR0;
                end
                ADR0: begin
                    if (we_q) begin
                        TD_o  <= dat_q[31:24];
                        state <= WD3;
                    end else begin
                        // hand TD to the SURF for one dead cycle
                        TD_o     <= '0;
                        TD_oe    <= '0;
                        TREQ_neg <= 1'b1;
                        state    <= TURN;
                    end
                end
                WD3: begin
                    TD_o  <= dat_q[23:16];
                    state <= WD2;
                end
                WD2: begin
                    TD_o  <= dat_q[15:8];
                    state <= WD1;
                end
                WD1: begin
                    TD_o  <= dat_q[7:0];
                    state <= WD0;
                end
                WD0: begin
                    TD_o     <= '0;
                    TREQ_neg <= 1'b1;
                    cnt      <= '0;
                    state    <= WAIT;
                end
                TURN: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!sreq_q) begin
                        if (we_q) begin
                            wbs_ack_o <= wbs_cyc_i;
                            TD_oe     <= 8'hFF;
                            state     <= DONE;
                        end else begin
                            rdata[23:16] <= td_q;
                            state        <= RD2;
                        end
                    end else if (cnt == CW'(TIMEOUT)) begin
                        wbs_err_o <= wbs_cyc_i;
                        wbs_dat_o <= ERR_DATA;
                        TD_oe     <= 8'hFF;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RD2: begin
                    rdata[15:8] <= td_q;
                    state       <= RD1;
                end
                RD1: begin
                    rdata[7:0] <= td_q;
                    state      <= RD0;
                end
                RD0: begin
                    wbs_dat_o <= {rdata, td_q};
                    wbs_ack_o <= wbs_cyc_i;
                    TD_oe     <= 8'hFF;
                    state     <= DONE;
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
